// File: rtl/sram_arbiter.sv
// Arbitrates the shared 8-bit external SRAM between the Z80 CPU port and the
// video fetch port, sequencing address setup, read sample and write strobe.
module sram_arbiter #(
  parameter int unsigned STARVE = 4,
  parameter logic [20:0] VBASE  = 21'h004000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpuReq,
  input  logic        cpuWe,
  input  logic [15:0] cpuA,
  input  logic [7:0]  cpuDi,
  output logic [7:0]  cpuDo,
  output logic        cpuAck,
  input  logic        vidReq,
  input  logic [12:0] vidA,
  output logic [7:0]  vidDo,
  output logic        vidAck,
  output logic        ramWe,
  inout  wire  [7:0]  ramD,
  output logic [20:0] ramA,
  output logic [2:0]  dbgState
);

  // Handshake: a requester raises req (level) with its address/data stable and
  // holds it until the one-cycle ack; everything is captured on the grant edge.
  // In the ack cycle that requester is ignored, so a late-dropping req is never
  // re-granted.

  localparam int SW = (STARVE > 0) ? $clog2(STARVE + 1) : 1;
  localparam logic [SW-1:0] STARVE_C = SW'(STARVE);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_S = 3'd2,
    WR_A = 3'd3,
    WR_P = 3'd4,
    WR_H = 3'd5
  } state_t;

  state_t        state, state_nx;
  logic          owner_vid;
  logic [7:0]    wdata;
  logic [SW-1:0] starve_cnt;
  logic          cpu_elig, vid_elig;
  logic          grant_vid, grant_cpu;
  logic          drive;

  assign cpu_elig  = cpuReq && !cpuAck;
  assign vid_elig  = vidReq && !vidAck;
  assign grant_vid = (state == IDLE) && vid_elig && (!cpu_elig || (starve_cnt < STARVE_C));
  assign grant_cpu = (state == IDLE) && !grant_vid && cpu_elig;

  assign drive    = (state == WR_A) || (state == WR_P) || (state == WR_H);
  assign ramD     = drive ? wdata : 8'bz;
  assign dbgState = state;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (grant_vid)      state_nx = RD_A;
        else if (grant_cpu) state_nx = cpuWe ? RD_A : WR_A;
      end
      RD_A:    state_nx = RD_S;
      RD_S:    state_nx = IDLE;
      WR_A:    state_nx = WR_P;
      WR_P:    state_nx = WR_H;
      WR_H:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      ramWe      <= 1'b1;
      ramA       <= '0;
      cpuAck     <= 1'b0;
      vidAck     <= 1'b0;
      cpuDo      <= '0;
      vidDo      <= '0;
      starve_cnt <= '0;
      owner_vid  <= 1'b0;
      wdata      <= '0;
    end else begin
      state  <= state_nx;
      // Strobe is low only while sitting in WR_P, giving setup and hold around it.
      ramWe  <= (state_nx != WR_P);
      cpuAck <= 1'b0;
      vidAck <= 1'b0;

      if (grant_vid) begin
        ramA      <= VBASE + {8'b0, vidA};
        owner_vid <= 1'b1;
      end else if (grant_cpu) begin
        ramA      <= {5'b00000, cpuA};
        owner_vid <= 1'b0;
        wdata     <= cpuDi;
      end

      if (state == RD_S) begin
        if (owner_vid) begin
          vidDo  <= ramD;
          vidAck <= 1'b1;
        end else begin
          cpuDo  <= ramD;
          cpuAck <= 1'b1;
        end
      end
      if (state == WR_H) cpuAck <= 1'b1;

      if (state == IDLE) begin
        if (grant_cpu || !cpu_elig)
          starve_cnt <= '0;
        else if (grant_vid && (starve_cnt != STARVE_C))
          starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter: a transaction-level reference model and a
// pin-level SRAM model, with directed cases for latency, wrap and mid-write reset.
module tb_sram_arbiter;

  localparam int unsigned STARVE = 4;
  localparam logic [20:0] VBASE  = 21'h004000;
  localparam int          MEMSZ  = 2097152;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        cpuReq = 0, cpuWe = 1, vidReq = 0;
  logic [15:0] cpuA = 0;
  logic [7:0]  cpuDi = 0;
  logic [12:0] vidA = 0;
  logic [7:0]  cpuDo, vidDo;
  logic        cpuAck, vidAck, ramWe;
  logic [20:0] ramA;
  logic [2:0]  dbgState;
  wire  [7:0]  ramD;

  sram_arbiter #(.STARVE(STARVE), .VBASE(VBASE)) dut (
    .clock(clock), .reset(reset),
    .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuA(cpuA), .cpuDi(cpuDi),
    .cpuDo(cpuDo), .cpuAck(cpuAck),
    .vidReq(vidReq), .vidA(vidA), .vidDo(vidDo), .vidAck(vidAck),
    .ramWe(ramWe), .ramD(ramD), .ramA(ramA), .dbgState(dbgState)
  );

  // second instance only for the address wrap case
  logic        vidReq2 = 0;
  logic [12:0] vidA2 = 0;
  logic [7:0]  cpuDo2, vidDo2;
  logic        cpuAck2, vidAck2, ramWe2;
  logic [20:0] ramA2;
  logic [2:0]  dbgState2;
  wire  [7:0]  ramD2;

  sram_arbiter #(.STARVE(STARVE), .VBASE(21'h1FFFFF)) dut_wrap (
    .clock(clock), .reset(reset),
    .cpuReq(1'b0), .cpuWe(1'b1), .cpuA(16'h0000), .cpuDi(8'h00),
    .cpuDo(cpuDo2), .cpuAck(cpuAck2),
    .vidReq(vidReq2), .vidA(vidA2), .vidDo(vidDo2), .vidAck(vidAck2),
    .ramWe(ramWe2), .ramD(ramD2), .ramA(ramA2), .dbgState(dbgState2)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] init_val(input logic [20:0] a);
    return a[7:0] ^ a[15:8] ^ {3'b000, a[20:16]} ^ 8'h5A;
  endfunction

  // pin-level SRAM: drives during read windows, captures on the rising strobe
  logic [7:0] sram_mem [MEMSZ];
  logic [7:0] ref_mem  [MEMSZ];
  logic       sram_oe = 1'b0;
  assign ramD = sram_oe ? sram_mem[ramA] : 8'bz;
  always @(posedge ramWe) if (!reset) sram_mem[ramA] = ramD;

  // reference model: an access occupies a fixed number of edges after the grant
  int          m_busy = 0, m_phase = 0, m_starve = 0;
  bit          m_vid = 0, m_write = 0;
  bit          m_cpuAck = 0, m_vidAck = 0, m_ramWe = 1;
  logic [7:0]  m_cpuDo = 0, m_vidDo = 0, m_wdata = 0;
  logic [20:0] m_ramA = 0;
  bit          cpu_e, vid_e;
  bit          chk_en = 0;

  always @(posedge clock) begin
    if (reset) begin
      m_busy = 0; m_phase = 0; m_starve = 0;
      m_cpuAck = 0; m_vidAck = 0; m_cpuDo = 0; m_vidDo = 0; m_ramA = 0;
    end else if (m_busy == 0) begin
      cpu_e = cpuReq && !m_cpuAck;
      vid_e = vidReq && !m_vidAck;
      m_cpuAck = 0; m_vidAck = 0;
      if (vid_e && (!cpu_e || m_starve < int'(STARVE))) begin
        m_vid = 1; m_write = 0; m_busy = 2; m_phase = 0;
        m_ramA = VBASE + 21'(vidA);
        m_starve = cpu_e ? ((m_starve + 1 > int'(STARVE)) ? int'(STARVE) : m_starve + 1) : 0;
      end else if (cpu_e) begin
        m_vid = 0; m_write = !cpuWe; m_phase = 0;
        m_busy = m_write ? 3 : 2;
        m_ramA = {5'b00000, cpuA};
        m_wdata = cpuDi;
        m_starve = 0;
      end else begin
        m_starve = 0;
      end
    end else begin
      m_cpuAck = 0; m_vidAck = 0;
      m_busy--; m_phase++;
      if (m_busy == 0) begin
        if (m_write) begin
          ref_mem[m_ramA] = m_wdata;
          m_cpuAck = 1;
        end else if (m_vid) begin
          m_vidDo = ref_mem[m_ramA];
          m_vidAck = 1;
        end else begin
          m_cpuDo = ref_mem[m_ramA];
          m_cpuAck = 1;
        end
      end
    end
    m_ramWe = !(m_busy > 0 && m_write && m_phase == 1);
  end

  // scoreboard: compare every cycle away from the active edge
  always @(negedge clock) begin
    sram_oe = (m_busy > 0) && !m_write;
    if (chk_en) begin
      check("ramWe", ramWe, m_ramWe);
      check("ramA", ramA, m_ramA);
      check("cpuAck", cpuAck, m_cpuAck);
      check("vidAck", vidAck, m_vidAck);
      check("cpuDo", cpuDo, m_cpuDo);
      check("vidDo", vidDo, m_vidDo);
      check("idle", dbgState == 3'd0, m_busy == 0);
      if (m_busy > 0 && m_write) check("ramD_wr", ramD, m_wdata);
    end
  end

  // driver tasks: called and return at #1 after a rising edge
  task automatic cpu_go(input logic we, input logic [15:0] a, input logic [7:0] d,
                        input bit hold, output int lat);
    lat = 0;
    cpuReq = 1; cpuWe = we; cpuA = a; cpuDi = d;
    do begin @(posedge clock); #1; lat++; end while (!cpuAck && lat < 200);
    check("cpu_ack_wait", cpuAck, 1'b1);
    if (!hold) cpuReq = 0;
  endtask

  task automatic vid_go(input logic [12:0] a, input bit hold, output int lat);
    lat = 0;
    vidReq = 1; vidA = a;
    do begin @(posedge clock); #1; lat++; end while (!vidAck && lat < 200);
    check("vid_ack_wait", vidAck, 1'b1);
    if (!hold) vidReq = 0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic cpu_random(input int n);
    int g, lat;
    logic [15:0] a;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 2))
        0:       a = 16'h4000 + 16'($urandom_range(0, 16'h1FFF));
        1:       a = 16'h8000 + 16'($urandom_range(0, 255));
        default: a = 16'($urandom_range(0, 16'hFFFF));
      endcase
      g = $urandom_range(0, 3);
      cpu_go(1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255)), (g == 0) && (i < n - 1), lat);
      idle_cycles(g);
    end
  endtask

  task automatic vid_random(input int n);
    int g, lat;
    for (int i = 0; i < n; i++) begin
      g = $urandom_range(0, 3);
      vid_go(13'($urandom_range(0, 13'h1FFF)), (g == 0) && (i < n - 1), lat);
      idle_cycles(g);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat_v;
    for (int i = 0; i < MEMSZ; i++) begin
      sram_mem[i] = init_val(21'(i));
      ref_mem[i]  = init_val(21'(i));
    end
    sram_mem[21'h008123] = 8'hA5;
    ref_mem[21'h008123]  = 8'hA5;

    repeat (3) @(posedge clock);
    #1 reset = 0;
    chk_en = 1;
    check("rst_ramWe", ramWe, 1'b1);
    check("rst_ramA", ramA, 21'h0);
    check("rst_acks", {cpuAck, vidAck}, 2'b00);
    check("rst_dos", {cpuDo, vidDo}, 16'h0000);
    check("rst_state", dbgState, 3'd0);

    // CPU read and write on an idle bus
    idle_cycles(2);
    cpu_go(1'b1, 16'h8123, 8'h00, 1'b0, lat);
    check("cpu_rd_lat", lat, 3);
    check("cpu_rd_data", cpuDo, 8'hA5);
    idle_cycles(2);
    cpu_go(1'b0, 16'h4000, 8'h3C, 1'b0, lat);
    check("cpu_wr_lat", lat, 4);
    check("cpu_wr_mem", sram_mem[21'h004000], 8'h3C);
    check("cpu_wr_keepdo", cpuDo, 8'hA5);

    // video read at the top of the window; cpuDo must not move
    idle_cycles(2);
    vid_go(13'h1FFF, 1'b0, lat);
    check("vid_rd_lat", lat, 3);
    check("vid_rd_data", vidDo, init_val(21'h005FFF));
    check("vid_keep_cpudo", cpuDo, 8'hA5);

    // wrap of VBASE + offset
    vidReq2 = 1; vidA2 = 13'h0002;
    @(posedge clock); #1;
    check("wrap_ramA", ramA2, 21'h000001);
    lat = 1;
    while (!vidAck2 && lat < 200) begin @(posedge clock); #1; lat++; end
    check("wrap_ack_lat", lat, 3);
    vidReq2 = 0;

    // CPU request raised during a video read is granted in the vidAck cycle
    idle_cycles(2);
    fork
      vid_go(13'h0123, 1'b0, lat_v);
      begin idle_cycles(1); cpu_go(1'b1, 16'h8123, 8'h00, 1'b0, lat); end
    join
    check("ack_cycle_grant_lat", lat, 5);
    check("ack_cycle_vid_lat", lat_v, 3);

    // both requesters held continuously
    idle_cycles(2);
    fork
      for (int i = 0; i < 10; i++) vid_go(13'(i * 37), i < 9, lat_v);
      for (int i = 0; i < 10; i++) cpu_go(1'(i % 2), 16'h8000 + 16'(i), 8'(i * 11), i < 9, lat);
    join
    idle_cycles(4);

    // randomized contention
    fork
      cpu_random(250);
      vid_random(250);
    join
    idle_cycles(4);

    // reset while the strobe is low
    cpu_go_abort();
    idle_cycles(4);
    cpu_go(1'b1, 16'h4000, 8'h00, 1'b0, lat);
    check("post_abort_lat", lat, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  task automatic cpu_go_abort();
    cpuReq = 1; cpuWe = 0; cpuA = 16'hF00D; cpuDi = 8'h77;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("abort_strobe_low", ramWe, 1'b0);
    reset = 1; cpuReq = 0;
    @(posedge clock); #1;
    reset = 0;
    check("abort_ramWe", ramWe, 1'b1);
    check("abort_state", dbgState, 3'd0);
    check("abort_noack", cpuAck, 1'b0);
  endtask

endmodule
